// File: rtl/row_dec_pkg.sv
// Shared types and the SDRAM-style command decode used by the banked row decoder.
package row_dec_pkg;

  typedef enum logic [1:0] {NOP, ACT, PRE, REF} cmd_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, PRECHARGING} bank_state_t;
  typedef enum logic {REF_IDLE, REFRESHING} ref_state_t;

  function automatic cmd_t decode_cmd(input logic ras, input logic cas, input logic we);
    cmd_t c;
    case ({ras, cas, we})
      3'b011:  c = ACT;
      3'b010:  c = PRE;
      3'b001:  c = REF;
      default: c = NOP;
    endcase
    return c;
  endfunction

  // Width of a down-counter that holds values 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_bank_ctrl.sv
// One bank: IDLE/ACTIVE/PRECHARGING FSM, open-row register, tRP timer and slice decoder.
module row_bank_ctrl
  import row_dec_pkg::*;
#(
  parameter int ROW_BITS = 8,
  parameter int T_RP     = 2,
  localparam int ROWS    = 2**ROW_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                act,
  input  logic                pre,
  input  logic [ROW_BITS-1:0] row,
  input  logic                ref_on,
  input  logic [ROW_BITS-1:0] ref_row,
  output logic [ROWS-1:0]     slice,
  output logic                act_ok,
  output logic                is_idle,
  output logic                is_open,
  output logic                is_busy
);

  localparam int CW = cnt_width(T_RP);

  bank_state_t         state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [ROW_BITS-1:0] open_row;
  logic                act_go;

  // A timer that reached zero on an earlier edge lets ACTIVATE in on this one.
  always_comb begin
    act_ok   = (state == IDLE) || (state == PRECHARGING && cnt == '0);
    act_go   = act && act_ok;
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE:        if (act_go) state_nx = ACTIVE;
      ACTIVE:      if (pre) begin
                     state_nx = PRECHARGING;
                     cnt_nx   = CW'(T_RP - 1);
                   end
      PRECHARGING: if (act_go)          state_nx = ACTIVE;
                   else if (cnt == '0)  state_nx = IDLE;
                   else                 cnt_nx   = cnt - 1'b1;
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      open_row <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (act_go) open_row <= row;
    end
  end

  always_comb begin
    slice = '0;
    if (ref_on)                slice[ref_row]  = 1'b1;
    else if (state == ACTIVE)  slice[open_row] = 1'b1;
  end

  always_comb begin
    is_idle = (state == IDLE);
    is_open = (state == ACTIVE);
    is_busy = (state == PRECHARGING);
  end

endmodule

// File: rtl/banked_row_decoder.sv
// Multi-bank row decoder: command decode, auto-refresh FSM with row counter, per-bank controllers.
module banked_row_decoder
  import row_dec_pkg::*;
#(
  parameter int ROW_BITS  = 8,
  parameter int BANKS     = 4,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 4,
  localparam int ROWS      = 2**ROW_BITS,
  localparam int BANK_BITS = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RAS,
  input  logic                  CAS,
  input  logic                  WE,
  input  logic                  AllBanks,
  input  logic [BANK_BITS-1:0]  BankAddrIn,
  input  logic [ROW_BITS-1:0]   RowAddrIn,
  output logic [BANKS*ROWS-1:0] RowAddrEn,
  output logic [BANKS-1:0]      BankOpen,
  output logic                  Busy,
  output logic [ROW_BITS-1:0]   RefRow,
  output logic                  CmdErr
);

  localparam int FW = cnt_width(T_RFC);

  cmd_t                cmd;
  ref_state_t          ref_state, ref_state_nx;
  logic [FW-1:0]       ref_cnt, ref_cnt_nx;
  logic [ROW_BITS-1:0] ref_row_nx;
  logic                err_nx, ref_busy, ref_done, ref_ok, ref_on;
  logic [BANKS-1:0]    hit, act_req, pre_req, act_ok, is_idle, is_busy;

  always_comb begin
    cmd      = decode_cmd(RAS, CAS, WE);
    ref_on   = (ref_state == REFRESHING);
    ref_busy = ref_on && (ref_cnt != '0);
    ref_done = ref_on && (ref_cnt == '0);
    ref_ok   = (&is_idle) && !ref_busy;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign hit[b]     = (BankAddrIn == BANK_BITS'(b));
    assign act_req[b] = (cmd == ACT) && !ref_busy && hit[b];
    assign pre_req[b] = (cmd == PRE) && (AllBanks || hit[b]);

    row_bank_ctrl #(
      .ROW_BITS (ROW_BITS),
      .T_RP     (T_RP)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .act     (act_req[b]),
      .pre     (pre_req[b]),
      .row     (RowAddrIn),
      .ref_on  (ref_on),
      .ref_row (RefRow),
      .slice   (RowAddrEn[b*ROWS +: ROWS]),
      .act_ok  (act_ok[b]),
      .is_idle (is_idle[b]),
      .is_open (BankOpen[b]),
      .is_busy (is_busy[b])
    );
  end

  // The final refresh cycle counts as idle so refreshes can run back to back.
  always_comb begin
    ref_state_nx = ref_state;
    ref_cnt_nx   = ref_cnt;
    ref_row_nx   = RefRow;
    err_nx       = 1'b0;
    if (ref_busy) begin
      ref_cnt_nx = ref_cnt - 1'b1;
    end else if (ref_done) begin
      ref_state_nx = REF_IDLE;
      ref_row_nx   = RefRow + 1'b1;
    end
    unique case (cmd)
      ACT:     err_nx = ref_busy || (|(hit & ~act_ok));
      REF:     if (ref_ok) begin
                 ref_state_nx = REFRESHING;
                 ref_cnt_nx   = FW'(T_RFC - 1);
               end else begin
                 err_nx = 1'b1;
               end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ref_state <= REF_IDLE;
      ref_cnt   <= '0;
      RefRow    <= '0;
      CmdErr    <= 1'b0;
    end else begin
      ref_state <= ref_state_nx;
      ref_cnt   <= ref_cnt_nx;
      RefRow    <= ref_row_nx;
      CmdErr    <= err_nx;
    end
  end

  always_comb Busy = (|is_busy) || ref_on;

endmodule

// File: tb/tb_banked_row_decoder.sv
// Directed bench for banked_row_decoder with default parameters (8 row bits, 4 banks, tRP 2, tRFC 4).
module tb_banked_row_decoder;

  localparam int ROW_BITS = 8;
  localparam int BANKS    = 4;
  localparam int T_RP     = 2;
  localparam int T_RFC    = 4;
  localparam int ROWS     = 256;
  localparam int W        = BANKS * ROWS;

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_NOP = 3'b111;

  logic          clk = 1'b0;
  logic          reset;
  logic          RAS, CAS, WE, AllBanks;
  logic [1:0]    BankAddrIn;
  logic [7:0]    RowAddrIn;
  logic [W-1:0]  RowAddrEn;
  logic [3:0]    BankOpen;
  logic          Busy;
  logic [7:0]    RefRow;
  logic          CmdErr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  banked_row_decoder #(
    .ROW_BITS (ROW_BITS),
    .BANKS    (BANKS),
    .T_RP     (T_RP),
    .T_RFC    (T_RFC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RAS        (RAS),
    .CAS        (CAS),
    .WE         (WE),
    .AllBanks   (AllBanks),
    .BankAddrIn (BankAddrIn),
    .RowAddrIn  (RowAddrIn),
    .RowAddrEn  (RowAddrEn),
    .BankOpen   (BankOpen),
    .Busy       (Busy),
    .RefRow     (RefRow),
    .CmdErr     (CmdErr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c, input logic all, input logic [1:0] b, input logic [7:0] r);
    {RAS, CAS, WE} = c;
    AllBanks       = all;
    BankAddrIn     = b;
    RowAddrIn      = r;
    tick();
    {RAS, CAS, WE} = C_NOP;
    AllBanks       = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < W; i++)
      if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic chk_en(input string tag, input logic [W-1:0] exp);
    tests++;
    assert (RowAddrEn === exp) else begin
      fails++;
      $error("FAIL %s RowAddrEn ones got=%0d exp=%0d first_diff_bit=%0d",
             tag, $countones(RowAddrEn), $countones(exp), first_diff(RowAddrEn, exp));
    end
  endtask

  function automatic logic [W-1:0] bit_at(input int i);
    logic [W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] ref_vec(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int b = 0; b < BANKS; b++) v[b*ROWS + k] = 1'b1;
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    {RAS, CAS, WE} = C_NOP;
    AllBanks = 1'b0; BankAddrIn = '0; RowAddrIn = '0;
    repeat (10) tick();
    chk("rst_hold_en", 32'($countones(RowAddrEn)), 32'd0);
    reset = 1'b1;
    tick();
    chk_en("rst_en", '0);
    chk("rst_open", 32'(BankOpen), 32'h0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_refrow", 32'(RefRow), 32'd0);
    chk("rst_err", 32'(CmdErr), 32'd0);

    // Open bank 2 row 4, re-activate it (error), open bank 1 row 255.
    issue(C_ACT, 1'b0, 2'd2, 8'd4);
    chk_en("act_b2r4", bit_at(2*256 + 4));
    chk("act_b2_open", 32'(BankOpen), 32'b0100);
    chk("act_b2_err", 32'(CmdErr), 32'd0);
    issue(C_ACT, 1'b0, 2'd2, 8'd9);
    chk("react_err", 32'(CmdErr), 32'd1);
    chk_en("react_keep", bit_at(2*256 + 4));
    issue(C_ACT, 1'b0, 2'd1, 8'd255);
    chk("err_pulse_end", 32'(CmdErr), 32'd0);
    chk_en("act_b1r255", bit_at(2*256 + 4) | bit_at(1*256 + 255));
    chk("act_b1_open", 32'(BankOpen), 32'b0110);

    // Precharge bank 2: slice clears, Busy for exactly T_RP cycles.
    issue(C_PRE, 1'b0, 2'd2, 8'd0);
    chk_en("pre_b2_en", bit_at(1*256 + 255));
    chk("pre_b2_open", 32'(BankOpen), 32'b0010);
    chk("pre_busy0", 32'(Busy), 32'd1);
    tick();
    chk("pre_busy1", 32'(Busy), 32'd1);
    tick();
    chk("pre_busy2", 32'(Busy), 32'd0);
    issue(C_PRE, 1'b0, 2'd1, 8'd0);
    tick(); tick();
    chk_en("pre_b1_en", '0);

    // Banks 0 and 3 closed together by an all-bank precharge.
    issue(C_ACT, 1'b0, 2'd0, 8'd7);
    issue(C_ACT, 1'b0, 2'd3, 8'd200);
    chk_en("act_b0_b3", bit_at(7) | bit_at(3*256 + 200));
    chk("act_b0_b3_open", 32'(BankOpen), 32'b1001);
    issue(C_PRE, 1'b1, 2'd1, 8'd0);
    chk_en("pre_all_en", '0);
    chk("pre_all_open", 32'(BankOpen), 32'h0);
    chk("pre_all_busy", 32'(Busy), 32'd1);
    issue(C_ACT, 1'b0, 2'd0, 8'd3);
    chk("act_early_err", 32'(CmdErr), 32'd1);
    chk("act_early_open", 32'(BankOpen), 32'h0);
    issue(C_ACT, 1'b0, 2'd0, 8'd3);
    chk("act_trp_err", 32'(CmdErr), 32'd0);
    chk("act_trp_open", 32'(BankOpen), 32'b0001);
    chk_en("act_trp_en", bit_at(3));
    chk("act_trp_busy", 32'(Busy), 32'd0);

    // Refresh with a bank open is refused.
    issue(C_REF, 1'b0, 2'd0, 8'd0);
    chk("ref_open_err", 32'(CmdErr), 32'd1);
    chk("ref_open_busy", 32'(Busy), 32'd0);
    chk_en("ref_open_en", bit_at(3));
    issue(C_PRE, 1'b0, 2'd0, 8'd0);
    tick(); tick();

    // Full sweep of back-to-back refreshes, with illegal commands mixed in.
    for (int k = 0; k < ROWS; k++) begin
      issue(C_REF, 1'b0, 2'd0, 8'd0);
      chk_en("ref_rows", ref_vec(k));
      chk("ref_refrow", 32'(RefRow), 32'(k));
      chk("ref_busy", 32'(Busy), 32'd1);
      for (int j = 1; j < T_RFC; j++) begin
        if (k == 5 && j == 1) begin
          issue(C_ACT, 1'b0, 2'd0, 8'd10);
          chk("act_in_ref_err", 32'(CmdErr), 32'd1);
          chk("act_in_ref_open", 32'(BankOpen), 32'h0);
        end else if (k == 6 && j == 1) begin
          issue(C_REF, 1'b0, 2'd0, 8'd0);
          chk("ref_in_ref_err", 32'(CmdErr), 32'd1);
        end else if (k == 7 && j == 1) begin
          issue(C_PRE, 1'b1, 2'd0, 8'd0);
          chk("pre_in_ref_err", 32'(CmdErr), 32'd0);
        end else begin
          tick();
        end
        chk_en("ref_hold", ref_vec(k));
        chk("ref_hold_busy", 32'(Busy), 32'd1);
      end
    end
    tick();
    chk_en("ref_wrap_en", '0);
    chk("ref_wrap_busy", 32'(Busy), 32'd0);
    chk("ref_wrap_row", 32'(RefRow), 32'd0);

    // Reset during a refresh aborts it and clears the row counter.
    issue(C_REF, 1'b0, 2'd0, 8'd0);
    repeat (T_RFC) tick();
    chk("ref_one_row", 32'(RefRow), 32'd1);
    issue(C_REF, 1'b0, 2'd0, 8'd0);
    chk_en("ref_row1", ref_vec(1));
    tick();
    reset = 1'b0;
    tick();
    chk_en("rst_mid_en", '0);
    chk("rst_mid_row", 32'(RefRow), 32'd0);
    chk("rst_mid_busy", 32'(Busy), 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/banked_row_decoder.md
# banked_row_decoder

Parametrised, multi-bank successor to the single-bank row decoder: it decodes SDRAM-style RAS/CAS/WE commands into per-bank one-hot row enables. Each bank has its own open-row register, a precharge timer and a state machine. The block adds an auto-refresh mode with an internal row counter. It sits between the memory command front end and the cell array, driving the word lines of every bank.

## Interface
- ROW_BITS, 8, row address width; ROWS = 2**ROW_BITS
- BANKS, 4, bank count (power of two, ≥1); BANK_BITS = max(1, $clog2(BANKS))
- T_RP, 2, precharge cycles (≥1)
- T_RFC, 4, refresh cycles per row (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- RAS  in  1  active-low row strobe
- CAS  in  1  active-low column strobe (refresh qualifier)
- WE  in  1  active-low write enable (precharge qualifier)
- AllBanks  in  1  precharge targets all banks (A10 equivalent)
- BankAddrIn  in  BANK_BITS  target bank
- RowAddrIn  in  ROW_BITS  row address
- RowAddrEn  out  BANKS*ROWS  one-hot per bank; bank b = [b*ROWS +: ROWS]
- BankOpen  out  BANKS  bank b in ACTIVE
- Busy  out  1  any bank PRECHARGING or refresh in progress
- RefRow  out  ROW_BITS  next row to be refreshed
- CmdErr  out  1  one-cycle pulse on an illegal command

## Operation
- Command decode happens at every rising clk, from the sampled {RAS,CAS,WE}:
  - 0,1,1: ACTIVATE
  - 0,1,0: PRECHARGE
  - 0,0,1: REFRESH
  - RAS=1 or any other code: NOP, no effect.
- Per-bank FSM states are IDLE, ACTIVE and PRECHARGING.
  - ACTIVATE to an IDLE bank latches RowAddrIn, sets bit RowAddrIn of that bank's slice, and moves the bank to ACTIVE.
  - ACTIVATE to an ACTIVE or PRECHARGING bank is ignored, and CmdErr pulses.
  - PRECHARGE to an ACTIVE bank clears its slice and moves it to PRECHARGING. The bank stays there T_RP cycles, then returns to IDLE.
  - PRECHARGE to an IDLE or PRECHARGING bank is a silent no-op.
  - PRECHARGE with AllBanks=1 applies this rule independently to every bank and ignores BankAddrIn.
- Refresh FSM states are REF_IDLE and REFRESHING.
  - REFRESH is legal only when every bank is IDLE and REF_IDLE. It then sets bit RefRow in every bank slice for T_RFC cycles.
  - At the end of refresh, all slices clear and RefRow increments modulo ROWS; ROWS-1 wraps to 0.
  - REFRESH while the legality condition fails is ignored, and CmdErr pulses.
  - Any ACTIVATE or REFRESH during REFRESHING is ignored, and CmdErr pulses. PRECHARGE during refresh is a no-op with no CmdErr.
- Invariant: at most one bit is set per bank slice at all times.
- Reset (reset=0 at a rising edge) takes priority over every command and aborts refresh or precharge mid-operation. Reset values:
  - RowAddrEn = 0, BankOpen = 0, Busy = 0, RefRow = 0, CmdErr = 0
  - every FSM in IDLE / REF_IDLE.

## Timing
- All outputs are registered. A command sampled at edge N is visible after edge N (latency 1), and no combinational path exists from inputs to outputs.
- ACTIVATE at N: the slice bit and BankOpen[b] are high from N.
- PRECHARGE at N: the slice and BankOpen[b] clear at N. Busy is high for cycles N..N+T_RP-1. An ACTIVATE to that bank is legal at edge N+T_RP.
- REFRESH at N: the refresh row bits and Busy are high for N..N+T_RFC-1. At edge N+T_RFC the bits clear, Busy falls and RefRow increments. A new command is legal at N+T_RFC.
- CmdErr is high for exactly the cycle after the offending edge.
- Simultaneous events: a precharge timer expiring at the same edge as an ACTIVATE to that bank means the bank is still PRECHARGING, so CmdErr pulses. The counter must reach 0 before that edge for the ACTIVATE to be accepted.

## Structure
- Package row_dec_pkg holds:
  - cmd_t enum (NOP, ACT, PRE, REF)
  - bank_state_t enum (IDLE, ACTIVE, PRECHARGING)
  - the command decode function.
- Sub-module row_bank_ctrl is instantiated once per bank in a generate loop. It contains the per-bank FSM, the open-row register, the T_RP counter and the slice decoder. Each instance has an inputs for a refresh-row overlay.
- The top level holds the command decode, the refresh FSM, the T_RFC counter, RefRow, the CmdErr register and the output concatenation.

## Test plan
- Reset low for 10 cycles, then release → all outputs 0 and RefRow=0.
- ACTIVATE bank 2 row 4 (defaults) → RowAddrEn[2*256+4]=1 and BankOpen=4'b0100 after the edge. PRECHARGE bank 2 → slice clears, Busy high 2 cycles.
- Second ACTIVATE to open bank 2 row 9 → CmdErr pulses 1 cycle, row 4 stays set. ACTIVATE bank 1 row 255 → independent, bit 1*256+255 set.
- Open banks 0 and 3, then PRECHARGE with AllBanks=1 → both clear in the same cycle. ACTIVATE at T_RP-1 cycles → CmdErr; at T_RP → accepted.
- 256 consecutive REFRESH commands spaced T_RFC apart → each asserts row k in all 4 slices for 4 cycles. RefRow walks 0..255, then wraps to 0.
- REFRESH while bank 0 open → CmdErr, no refresh. Reset asserted mid-refresh → RowAddrEn=0, RefRow=0 after that edge.
